// File: rtl/cross_bar_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cross_bar_slave_mem                                            |
// | Purpose : Memory-backed responder for one crossbar slave port. Accepts a |
// |           request, waits a programmable number of cycles, then performs  |
// |           a word write or read on an internal array and pulses ack.      |
// | Ports   : clk          - slave-side clock                                |
// |           aresetn      - synchronous reset, ACTIVE HIGH (legacy name)    |
// |           slave_req    - request, held until ack is seen                 |
// |           slave_addr   - byte address (word index in [log2(DEPTH)+1:2])  |
// |           slave_cmd    - 1 = write, 0 = read                             |
// |           slave_wdata  - write data                                      |
// |           slave_ack    - one-cycle completion pulse (registered)         |
// |           slave_rdata  - read data, non-zero only during ack (registered)|
// | Options : CROSS_BAR_SLAVE_MEM_RANDOM_WAIT_EN adds an 8-bit LFSR that     |
// |           stretches each wait by 0..3 extra cycles.                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cross_bar_slave_mem #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                LATENCY  = 2,
  parameter logic [DATA_W-1:0] BAD_DATA = 32'hBAD0BAD0
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef CROSS_BAR_SLAVE_MEM_RANDOM_WAIT_EN
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mis_q, mis_d;
  logic              cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  wait_val;
  logic              in_idle;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_mis;
  logic              cur_cmd;
  logic [DATA_W-1:0] cur_wdata;
  logic              go_ack;
  logic              mem_we;

  // Upper address bits (including slave-select) alias the array on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^slave_addr[ADDR_W-1:IDX_W+2];

`ifdef CROSS_BAR_SLAVE_MEM_RANDOM_WAIT_EN
  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; its two LSBs add 0..3 wait cycles.
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (aresetn) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  assign wait_val = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign wait_val = CNT_W'(LATENCY);
`endif

  // A zero wait commits on the accept edge itself, before the latches are
  // loaded, so the commit path picks live inputs while idle.
  assign in_idle   = (state_q == ST_IDLE);
  assign cur_idx   = in_idle ? slave_addr[IDX_W+1:2]       : idx_q;
  assign cur_mis   = in_idle ? (slave_addr[1:0] != 2'b00)  : mis_q;
  assign cur_cmd   = in_idle ? slave_cmd                   : cmd_q;
  assign cur_wdata = in_idle ? slave_wdata                 : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    go_ack  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slave_req) begin
          idx_d   = slave_addr[IDX_W+1:2];
          mis_d   = (slave_addr[1:0] != 2'b00);
          cmd_d   = slave_cmd;
          wdata_d = slave_wdata;
          cnt_d   = wait_val;
          if (wait_val == '0) begin
            state_d = ST_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACK;
          go_ack  = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!slave_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ack and read data are registered on the edge that enters ACK.
  always_comb begin
    ack_d   = go_ack;
    rdata_d = '0;
    if (go_ack && !cur_cmd) begin
      rdata_d = cur_mis ? BAD_DATA : mem[cur_idx];
    end
  end

  // Reset has priority, so a transaction aborted on its commit edge is lost.
  assign mem_we = go_ack && cur_cmd && !cur_mis && !aresetn;

  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= cur_wdata;
  end

  always_ff @(posedge clk) begin
    if (aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign slave_ack   = ack_q;
  assign slave_rdata = rdata_q;

endmodule
`default_nettype wire
